// File: rtl/regfile_writeback_ctrl.sv
// Write-side master for the 8x16 register file: merges ALU and load results into
// one in-order queue, drains one entry per cycle and forwards pending data to R/S.
module regfile_writeback_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_adr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_adr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic [AW-1:0] W_Adr,
  output logic          we,
  output logic [DW-1:0] W,
  input  logic [AW-1:0] R_Adr,
  input  logic [AW-1:0] S_Adr,
  input  logic [DW-1:0] R_in,
  input  logic [DW-1:0] S_in,
  output logic [DW-1:0] R_fwd,
  output logic [DW-1:0] S_fwd,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0] FULL_M1 = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] FULL_M2 = (PW+1)'(DEPTH - 2);

  logic [AW-1:0] q_adr  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, alu_slot;
  logic [PW:0]   count, n_push;
  logic          mem_push, alu_push, pop;

  // Ready uses the registered count only; the ALU needs two free slots when
  // the load path may take the last one, since the load is pushed first.
  assign mem_ready = (count < FULL);
  assign alu_ready = (count <= FULL_M2) || ((count == FULL_M1) && !mem_valid);
  assign mem_push  = mem_valid && mem_ready;
  assign alu_push  = alu_valid && alu_ready;
  assign pop       = (count != '0);
  assign alu_slot  = wr_ptr + PW'(mem_push);
  assign n_push    = (PW+1)'(mem_push) + (PW+1)'(alu_push);
  assign idle      = (count == '0) && !we;

  // Queue storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      q_adr[wr_ptr]  <= mem_adr;
      q_data[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      q_adr[alu_slot]  <= alu_adr;
      q_data[alu_slot] <= alu_data;
    end
  end

  // Queue pointers/count and the registered write-port stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      we     <= 1'b0;
      W_Adr  <= '0;
      W      <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count + n_push - (PW+1)'(pop);
      if (pop) begin
        W_Adr  <= q_adr[rd_ptr];
        W      <= q_data[rd_ptr];
        we     <= 1'b1;
        rd_ptr <= rd_ptr + PW'(1);
      end else begin
        we <= 1'b0;
      end
    end
  end

  // Oldest-to-youngest scan, so the youngest matching entry overrides.
  function automatic logic [DW-1:0] fwd_operand(input logic [AW-1:0] adr,
                                                input logic [DW-1:0] rf_val);
    logic [DW-1:0] val;
    logic [PW-1:0] idx;
    val = rf_val;
    idx = rd_ptr;
    if (we && (W_Adr == adr)) val = W;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (q_adr[idx] == adr)) val = q_data[idx];
    end
    return val;
  endfunction

  always_comb begin
    R_fwd = fwd_operand(R_Adr, R_in);
    S_fwd = fwd_operand(S_Adr, S_in);
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl with a small register-file model
// feeding the R/S operands.
module tb_regfile_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [2:0]  alu_adr, mem_adr;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [2:0]  W_Adr;
  logic        we;
  logic [15:0] W;
  logic [2:0]  R_Adr, S_Adr;
  logic [15:0] R_in, S_in, R_fwd, S_fwd;
  logic        idle;

  logic [15:0] rf [8];
  logic        use_model;
  logic [15:0] r_force, s_force;

  int checks = 0;
  int errors = 0;

  regfile_writeback_ctrl #(.DW(16), .AW(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_adr(alu_adr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_adr(mem_adr), .mem_data(mem_data), .mem_ready(mem_ready),
    .W_Adr(W_Adr), .we(we), .W(W),
    .R_Adr(R_Adr), .S_Adr(S_Adr), .R_in(R_in), .S_in(S_in),
    .R_fwd(R_fwd), .S_fwd(S_fwd), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) rf[k] <= 16'h0000;
    end else if (we) begin
      rf[W_Adr] <= W;
    end
  end

  assign R_in = use_model ? rf[R_Adr] : r_force;
  assign S_in = use_model ? rf[S_Adr] : s_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [18:0] exp_w [7];
    int nexp;
    int nwr;

    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_adr = '0; mem_adr = '0; alu_data = '0; mem_data = '0;
    R_Adr = '0; S_Adr = '0; use_model = 1'b1; r_force = '0; s_force = '0;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_we",        32'(we),        32'd0);
    chk("rst_W",         32'(W),         32'd0);
    chk("rst_W_Adr",     32'(W_Adr),     32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("rst_idle",      32'(idle),      32'd1);
    step();
    reset = 1'b1;

    // Single ALU write to r3
    alu_valid = 1'b1; alu_adr = 3'd3; alu_data = 16'h1234; R_Adr = 3'd3;
    @(negedge clk);
    chk("t2_alu_ready",     32'(alu_ready), 32'd1);
    chk("t2_fwd_unaccepted", 32'(R_fwd),    32'h0000);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t2_we_queued",  32'(we),    32'd0);
    chk("t2_idle_busy",  32'(idle),  32'd0);
    chk("t2_fwd_queue",  32'(R_fwd), 32'h1234);
    step();
    @(negedge clk);
    chk("t2_we",     32'(we),    32'd1);
    chk("t2_W_Adr",  32'(W_Adr), 32'd3);
    chk("t2_W",      32'(W),     32'h1234);
    chk("t2_fwd_out", 32'(R_fwd), 32'h1234);
    step();
    @(negedge clk);
    chk("t2_we_done", 32'(we),    32'd0);
    chk("t2_idle",    32'(idle),  32'd1);
    chk("t2_W_hold",  32'(W),     32'h1234);
    chk("t2_rf_r3",   32'(R_fwd), 32'h1234);
    step();

    // Same-cycle mem + ALU to r1: mem first, ALU youngest
    mem_valid = 1'b1; mem_adr = 3'd1; mem_data = 16'h5555;
    alu_valid = 1'b1; alu_adr = 3'd1; alu_data = 16'hAAAA; R_Adr = 3'd1;
    @(negedge clk);
    chk("t3_mem_ready", 32'(mem_ready), 32'd1);
    chk("t3_alu_ready", 32'(alu_ready), 32'd1);
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    @(negedge clk);
    chk("t3_fwd_young", 32'(R_fwd), 32'hAAAA);
    step();
    @(negedge clk);
    chk("t3_first_we", 32'(we),    32'd1);
    chk("t3_first_W",  32'(W),     32'h5555);
    chk("t3_fwd_q",    32'(R_fwd), 32'hAAAA);
    step();
    @(negedge clk);
    chk("t3_second_W", 32'(W),     32'hAAAA);
    chk("t3_fwd_out",  32'(R_fwd), 32'hAAAA);
    step();
    @(negedge clk);
    chk("t3_idle",   32'(idle),  32'd1);
    chk("t3_rf_r1",  32'(R_fwd), 32'hAAAA);
    step();

    // R_Adr=2 with forced R_in, only r5 pending
    mem_valid = 1'b1; mem_adr = 3'd5; mem_data = 16'h00FF;
    R_Adr = 3'd2; S_Adr = 3'd5; use_model = 1'b0; r_force = 16'hBEEF; s_force = 16'h0000;
    @(negedge clk);
    chk("t5_S_unaccepted", 32'(S_fwd), 32'h0000);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t5_R_fwd", 32'(R_fwd), 32'hBEEF);
    chk("t5_S_fwd", 32'(S_fwd), 32'h00FF);
    step();
    @(negedge clk);
    chk("t5_W_Adr",   32'(W_Adr), 32'd5);
    chk("t5_S_out",   32'(S_fwd), 32'h00FF);
    step();
    use_model = 1'b1;
    @(negedge clk);
    chk("t5_idle", 32'(idle), 32'd1);
    step();

    // Both producers valid every cycle: ALU stalls at count=3
    nexp = 0;
    nwr = 0;
    for (int p = 0; p < 5; p++) begin
      mem_valid = 1'b1; mem_adr = 3'(p);     mem_data = 16'h1000 + 16'(p);
      alu_valid = 1'b1; alu_adr = 3'(p + 2); alu_data = 16'h2000 + 16'(p);
      @(negedge clk);
      chk("t4_mem_ready", 32'(mem_ready), 32'd1);
      chk("t4_alu_ready", 32'(alu_ready), (p < 2) ? 32'd1 : 32'd0);
      if (we) begin
        if (nwr < 7) chk("t4_w_order", 32'({W_Adr, W}), 32'(exp_w[nwr]));
        nwr++;
      end
      exp_w[nexp] = {3'(p), 16'h1000 + 16'(p)};
      nexp++;
      if (p < 2) begin
        exp_w[nexp] = {3'(p + 2), 16'h2000 + 16'(p)};
        nexp++;
      end
      step();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int d = 0; d < 6; d++) begin
      @(negedge clk);
      if (we) begin
        if (nwr < 7) chk("t4_w_order", 32'({W_Adr, W}), 32'(exp_w[nwr]));
        nwr++;
      end
      step();
    end
    chk("t4_write_count", 32'(nwr), 32'd7);
    @(negedge clk);
    chk("t4_idle", 32'(idle), 32'd1);
    step();

    // Reset pulse with 3 entries queued
    mem_valid = 1'b1; mem_adr = 3'd6; mem_data = 16'h0606;
    alu_valid = 1'b1; alu_adr = 3'd7; alu_data = 16'h0707;
    step();
    mem_data = 16'h1606; alu_data = 16'h1707;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    chk("t6_we_before", 32'(we), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_we",        32'(we),        32'd0);
    chk("t6_rst_W",         32'(W),         32'd0);
    chk("t6_rst_W_Adr",     32'(W_Adr),     32'd0);
    chk("t6_rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("t6_rst_mem_ready", 32'(mem_ready), 32'd1);
    chk("t6_rst_idle",      32'(idle),      32'd1);
    reset = 1'b1;
    for (int d = 0; d < 6; d++) begin
      @(negedge clk);
      chk("t6_no_write", 32'(we), 32'd0);
    end
    chk("t6_idle", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
